// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
// State, instruction class, opcode/funct constants and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_SHIFT, CL_I, CL_LW, CL_SW,
    CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
  } iclass_t;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [2:0] OP_IFMT_HI = 3'b001;
  localparam logic [5:0] FN_JR      = 6'b001000;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic is_shift_funct(input logic [5:0] fn);
    return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  endfunction

  // add/addu/sub/subu/and/or/xor/nor plus slt/sltu
  function automatic logic is_alu_funct(input logic [5:0] fn);
    return (fn[5:3] == 3'b100) || (fn == 6'b101010) || (fn == 6'b101011);
  endfunction

endpackage

// File: rtl/multicycle_control32_if.sv
// rtl/multicycle_control32_if.sv - control unit <-> datapath/memory signal bundle
// master = control unit, slave = datapath side.
interface multicycle_control32_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       alu_zero;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic       sftmd;
  logic [1:0] pc_src;
  logic [1:0] reg_dst;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       instr_done;
  logic       illegal;
  logic       timeout;

  modport master (
    input  opcode, funct, mem_ready, alu_zero,
    output mem_req, mem_we, ir_write, pc_write, reg_write, mem_to_reg, alu_src, sftmd,
           pc_src, reg_dst, alu_op, state, instr_done, illegal, timeout
  );

  modport slave (
    output opcode, funct, mem_ready, alu_zero,
    input  mem_req, mem_we, ir_write, pc_write, reg_write, mem_to_reg, alu_src, sftmd,
           pc_src, reg_dst, alu_op, state, instr_done, illegal, timeout
  );
endinterface

// File: rtl/instr_classify.sv
// rtl/instr_classify.sv - combinational opcode/funct to instruction class decode
// Unrecognised encodings map to CL_NONE.
module instr_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = CL_NONE;
    if (opcode == OP_RTYPE) begin
      if (funct == FN_JR)              cls = CL_JR;
      else if (is_shift_funct(funct))  cls = CL_SHIFT;
      else if (is_alu_funct(funct))    cls = CL_R;
    end else if (opcode[5:3] == OP_IFMT_HI) begin
      cls = CL_I;
    end else begin
      case (opcode)
        OP_LW:   cls = CL_LW;
        OP_SW:   cls = CL_SW;
        OP_BEQ:  cls = CL_BEQ;
        OP_BNE:  cls = CL_BNE;
        OP_J:    cls = CL_J;
        OP_JAL:  cls = CL_JAL;
        default: cls = CL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control32.sv
// rtl/multicycle_control32.sv - multicycle MIPS control FSM with memory wait timeout
// Outputs decode from registered state/class; strobes are held low while reset is high.
module multicycle_control32
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit EN_ILLEGAL_TRAP = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  multicycle_control32_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     st;
  iclass_t    cls_q;
  iclass_t    cls_d;
  logic [7:0] wait_cnt;
  logic       illegal_q;
  logic       timeout_q;
  logic       wait_last;

  instr_classify u_classify (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls_d)
  );

  assign wait_last = (wait_cnt == WAIT_LAST);

  // Any cycle that does not keep waiting clears the counter, so every entry
  // into FETCH/MEM starts counting from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= ST_FETCH;
      cls_q     <= CL_NONE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (st)
        ST_FETCH: begin
          if (bus.mem_ready) st <= ST_DECODE;
          else if (wait_last) begin
            st        <= ST_TRAP;
            timeout_q <= 1'b1;
          end else wait_cnt <= wait_cnt + 8'd1;
        end
        ST_DECODE: begin
          cls_q <= cls_d;
          if (cls_d != CL_NONE) st <= ST_EXEC;
          else if (EN_ILLEGAL_TRAP) begin
            st        <= ST_TRAP;
            illegal_q <= 1'b1;
          end else st <= ST_FETCH;
        end
        ST_EXEC: begin
          case (cls_q)
            CL_R, CL_SHIFT, CL_I: st <= ST_WB;
            CL_LW, CL_SW:         st <= ST_MEM;
            default:              st <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ready) st <= (cls_q == CL_LW) ? ST_WB : ST_FETCH;
          else if (wait_last) begin
            st        <= ST_TRAP;
            timeout_q <= 1'b1;
          end else wait_cnt <= wait_cnt + 8'd1;
        end
        ST_WB:   st <= ST_FETCH;
        ST_TRAP: st <= ST_TRAP;
        default: st <= ST_FETCH;
      endcase
    end
  end

  assign bus.state   = st;
  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src    = 1'b0;
    bus.sftmd      = 1'b0;
    bus.pc_src     = PC_SRC_PC4;
    bus.reg_dst    = REG_DST_RT;
    bus.alu_op     = ALU_ADD;
    bus.instr_done = 1'b0;
    if (!reset) begin
      case (st)
        ST_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        ST_DECODE: bus.instr_done = (cls_d == CL_NONE) && !EN_ILLEGAL_TRAP;
        ST_EXEC: begin
          case (cls_q)
            CL_R, CL_SHIFT: begin
              bus.alu_op = ALU_FUNCT;
              bus.sftmd  = (cls_q == CL_SHIFT);
            end
            CL_I: begin
              bus.alu_op  = ALU_FUNCT;
              bus.alu_src = 1'b1;
            end
            CL_LW, CL_SW: bus.alu_src = 1'b1;
            CL_BEQ, CL_BNE: begin
              bus.alu_op     = ALU_SUB;
              bus.pc_src     = PC_SRC_BRANCH;
              bus.pc_write   = (cls_q == CL_BEQ) ? bus.alu_zero : !bus.alu_zero;
              bus.instr_done = 1'b1;
            end
            CL_J, CL_JAL: begin
              bus.pc_write   = 1'b1;
              bus.pc_src     = PC_SRC_JUMP;
              bus.reg_write  = (cls_q == CL_JAL);
              bus.reg_dst    = (cls_q == CL_JAL) ? REG_DST_R31 : REG_DST_RT;
              bus.instr_done = 1'b1;
            end
            CL_JR: begin
              bus.pc_write   = 1'b1;
              bus.pc_src     = PC_SRC_REG;
              bus.instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          bus.mem_req    = 1'b1;
          bus.mem_we     = (cls_q == CL_SW);
          bus.instr_done = (cls_q == CL_SW) && bus.mem_ready;
        end
        ST_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = (cls_q == CL_R || cls_q == CL_SHIFT) ? REG_DST_RD : REG_DST_RT;
          bus.mem_to_reg = (cls_q == CL_LW);
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control32.md
MULTICYCLE_CONTROL32 -- requirements
Module: multicycle_control32

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max wait cycles for mem_ready in FETCH/MEM before trap; legal range 1..255.
REQ-002 SHALL have parameter EN_ILLEGAL_TRAP, default 1: 1 = unknown opcode/funct enters TRAP; 0 = treated as NOP.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports opcode  in  6  instr[31:26] and funct  in  6  instr[5:0], both from the external IR.
REQ-006 SHALL have ports mem_ready  in  1  memory handshake ack, and alu_zero  in  1  ALU zero flag.
REQ-007 SHALL have outputs mem_req, mem_we, ir_write, pc_write, reg_write, mem_to_reg, alu_src, sftmd (1 bit each): strobes/selects.
REQ-008 SHALL have outputs pc_src (2: 0=PC+4, 1=branch target, 2=jump target, 3=rs), reg_dst (2: 0=rt, 1=rd, 2=r31), alu_op (2: 00 add, 01 sub/compare, 10 funct/opcode).
REQ-009 SHALL have outputs state (3), instr_done (1), illegal (1) and timeout (1).

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, with all outputs decoded from registered state and latched class.
REQ-011 FETCH SHALL assert mem_req; on mem_ready=1 it SHALL pulse ir_write and pc_write (pc_src=0) that cycle and go to DECODE; otherwise it stays.
REQ-012 DECODE SHALL latch the class of opcode/funct (R, I-format opcode[5:3]=001, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, jr R/001000, shift R/funct 00,02,03,04,06,07) and go to EXEC; an unknown encoding goes to TRAP (EN_ILLEGAL_TRAP=1) or FETCH with instr_done (=0).
REQ-013 EXEC, R/I-format: alu_op=10, alu_src=I-format, sftmd per class; next WB.
REQ-014 EXEC, lw/sw: alu_op=00, alu_src=1; next MEM.
REQ-015 EXEC, beq/bne: alu_op=01; pc_write=alu_zero (beq) or !alu_zero (bne), pc_src=1; next FETCH, instr_done=1.
REQ-016 EXEC, j: pc_write, pc_src=2; jal: additionally reg_write, reg_dst=2; jr: pc_write, pc_src=3, reg_write=0; all next FETCH, instr_done=1.
REQ-017 MEM SHALL assert mem_req, with mem_we=1 for sw only; on mem_ready, sw goes to FETCH with instr_done=1 and lw goes to WB.
REQ-018 WB SHALL assert reg_write, reg_dst=1 for R and 0 otherwise, mem_to_reg=1 for lw; next FETCH, instr_done=1.
REQ-019 Zero-wait latency SHALL be 3 cycles for branch/jump, 4 for R/I/sw, 5 for lw.
REQ-020 A wait counter SHALL clear on entering FETCH/MEM and increment each cycle mem_ready=0; when it reaches MEM_TIMEOUT it SHALL go to TRAP and set timeout.
REQ-021 mem_ready outside FETCH/MEM SHALL be ignored; mem_ready in the cycle the counter reaches MEM_TIMEOUT SHALL win (no trap).
REQ-022 TRAP SHALL be sticky until reset; all strobes 0; illegal or timeout held at 1.
REQ-023 instr_done SHALL be a single-cycle pulse, concurrent with the last strobe of the instruction.

Reset
REQ-024 While reset=1: state=FETCH, counter=0, class cleared, illegal=timeout=0, and every strobe output (mem_req, mem_we, ir_write, pc_write, reg_write, instr_done) forced to 0.
REQ-025 Reset asserted mid-instruction SHALL abort it immediately with no further strobes; the first cycle after release is FETCH with mem_req=1.

Structure
REQ-026 State encodings, opcode/funct constants and pc_src/reg_dst/alu_op codes SHALL live in shared package mips_ctrl_pkg.
REQ-027 Combinational opcode/funct classification SHALL be one sub-module, instr_classify; FSM and counter stay in the top.

Verification
REQ-028 Zero-wait add (op 000000, funct 100000) -> states 0,1,2,4,0; reg_write=1, reg_dst=1 in cycle 4; instr_done 1 cycle.
REQ-029 lw, mem_ready low 3 cycles in MEM -> MEM held 4 cycles; WB with mem_to_reg=1, reg_dst=0; total 8 cycles.
REQ-030 beq with alu_zero=1, then bne with alu_zero=1 -> pc_write=1, pc_src=1 for the first; pc_write=0 for the second; both 3 cycles.
REQ-031 jal -> EXEC asserts pc_write, pc_src=2, reg_write, reg_dst=2; jr (funct 001000) -> pc_src=3, reg_write=0.
REQ-032 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles, timeout=1 until reset; mem_ready on the 4th cycle -> DECODE.
REQ-033 Opcode 111111 -> TRAP, illegal=1 (EN_ILLEGAL_TRAP=1) / FETCH, no strobes (=0); reset pulsed during MEM of sw -> mem_we drops same cycle.
